// File: rtl/ring_noc_pkg.sv
// Shared ring NoC definitions: packet layout, field slices and port encodings.
// Used by routers, traffic generators and the link buffers.
package ring_noc_pkg;

  localparam int PKT_W     = 49;
  localparam int VALID_BIT = 48;

  localparam int TS_MSB  = 47;
  localparam int TS_LSB  = 32;
  localparam int SRC_MSB = 31;
  localparam int SRC_LSB = 16;
  localparam int DST_MSB = 15;
  localparam int DST_LSB = 0;

  typedef struct packed {
    logic        valid;
    logic [15:0] ts;
    logic [15:0] src;
    logic [15:0] dst;
  } ring_pkt_t;

  localparam logic [1:0] PORT_LOCAL = 2'b00;
  localparam logic [1:0] PORT_EAST  = 2'b01;
  localparam logic [1:0] PORT_WEST  = 2'b10;

  // True when a raw link word carries a packet.
  function automatic logic pkt_is_valid(input logic [PKT_W-1:0] pkt);
    return pkt[VALID_BIT];
  endfunction

endpackage

// File: rtl/ring_link_fifo.sv
// Plain circular buffer: push/pop/count/full/empty, no policy.
// Caller contract: never push when full unless popping in the same cycle,
// never pop when empty. pop_data shows the head entry combinationally.
module ring_link_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage has no reset: contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/ring_link_buffer.sv
// Elastic, retiming stage on one ring link direction. Absorbs packets still in
// flight after backpressure is raised, drops and counts anything beyond that,
// and counts forwarded packets.
//
// Link handshake: a beat transfers whenever its VALID bit (MSB) is set; there
// is no ready. up_bp_out is a registered stop request that upstream sees one
// cycle late, so BP_THRESHOLD slack entries stay free for in-flight beats; a
// valid beat arriving while full with no pop is dropped. dn_bp_in is sampled
// at the edge and only blocks the next pop.
module ring_link_buffer
  import ring_noc_pkg::*;
#(
  parameter int PACKET_SIZE  = PKT_W,
  parameter int DEPTH        = 4,
  parameter int BP_THRESHOLD = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PACKET_SIZE-1:0]  up_pkt_in,
  output logic                    up_bp_out,
  output logic [PACKET_SIZE-1:0]  dn_pkt_out,
  input  logic                    dn_bp_in,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [63:0]             fwd_count,
  output logic [31:0]             drop_count,
  output logic                    overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ring_link_buffer: DEPTH must be a power of two, at least 2");
  end
  if (BP_THRESHOLD < 1 || BP_THRESHOLD > DEPTH) begin : g_bad_thresh
    $error("ring_link_buffer: BP_THRESHOLD must be in 1..DEPTH");
  end

  logic                   in_valid;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   full;
  logic                   empty;
  logic [PACKET_SIZE-1:0] head;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_next;
  logic [CW-1:0]          free_next;
  logic [31:0]            drop_cnt_q;

  assign in_valid = up_pkt_in[PACKET_SIZE-1];
  assign pop      = !empty && !dn_bp_in;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push     = in_valid && (!full || pop);
  assign drop     = in_valid && full && !pop;

  ring_link_fifo #(
    .WIDTH (PACKET_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (up_pkt_in),
    .pop       (pop),
    .pop_data  (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Post-edge occupancy and free space, used to register backpressure.
  always_comb begin
    count_next = count;
    if (push && !pop) count_next = count + 1'b1;
    if (pop && !push) count_next = count - 1'b1;
    free_next = CW'(DEPTH) - count_next;
  end

  // Output register, backpressure and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_pkt_out <= '0;
      up_bp_out  <= 1'b0;
      fwd_count  <= '0;
      drop_cnt_q <= '0;
      overflow   <= 1'b0;
    end else begin
      dn_pkt_out <= pop ? head : '0;
      up_bp_out  <= (free_next < CW'(BP_THRESHOLD));
      if (pop) fwd_count <= fwd_count + 64'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign occupancy  = count;
  assign drop_count = drop_cnt_q;

endmodule

// File: doc/ring_link_buffer.md
Name: ring_link_buffer

Overview:
- Elastic pipeline stage on each inter-router ring link. It sits between one router's link_*_out and the next router's link_*_in.
- Absorbs packets that are still in flight after backpressure is raised, because both sides see backpressure one cycle late. It also retimes the link and counts forwarded and dropped packets per link.
- One instance per direction per hop: east chain and west chain.

Parameters:
- PACKET_SIZE, 49: packet width. Bit PACKET_SIZE-1 = VALID, [47:32] = timestamp, [31:16] = source, [15:0] = destination.
- DEPTH, 4: FIFO entries. Must be a power of 2, at least 2.
- BP_THRESHOLD, 2: up_bp_out asserts when free entries < BP_THRESHOLD. Must be in 1..DEPTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- up_pkt_in  in  PACKET_SIZE  packet from upstream router output; valid when MSB=1
- up_bp_out  out  1  backpressure to upstream router (its backpressure_*_rd); registered
- dn_pkt_out  out  PACKET_SIZE  packet to downstream router input; registered; all-zero when idle
- dn_bp_in  in  1  backpressure from downstream router (its backpressure_*_wr)
- occupancy  out  $clog2(DEPTH)+1  current entry count
- fwd_count  out  64  packets delivered downstream
- drop_count  out  32  valid packets dropped on overflow; saturating
- overflow  out  1  sticky; set on first drop

Behaviour:
- Reset (async, rst_n=0), all of the following:
  - dn_pkt_out = 0, up_bp_out = 0, occupancy = 0, fwd_count = 0, drop_count = 0, overflow = 0.
  - Read and write pointers = 0. Storage contents are don't-care.
  - Reset mid-stream discards all held packets; nothing is replayed.
- Push:
  - At each posedge, if up_pkt_in[PACKET_SIZE-1]=1 and (count < DEPTH or pop occurs this cycle), write up_pkt_in at wr_ptr, then wr_ptr++ modulo DEPTH.
  - up_pkt_in with MSB=0 is ignored regardless of its other bits.
- Pop:
  - At each posedge, if count > 0 and dn_bp_in=0, dn_pkt_out <= entry at rd_ptr, rd_ptr++, fwd_count++.
  - Otherwise dn_pkt_out <= 0.
  - Each packet appears on dn_pkt_out for exactly one cycle.
- No bypass. A packet pushed at edge N can pop at edge N+1 at the earliest, so minimum latency is 2 cycles input-to-output.
- Simultaneous push and pop:
  - Both occur; count is unchanged.
  - When full, a pop frees the slot, so the push is accepted with no drop.
- Overflow: a valid input arriving when count = DEPTH and no pop occurs is dropped.
  - drop_count increments and saturates at 2^32-1.
  - overflow <= 1 and stays 1 until reset.
  - Pointers and storage are unchanged.
- Backpressure: up_bp_out <= ((DEPTH - count_next) < BP_THRESHOLD), where count_next is the post-edge count. Registered, so it is visible to upstream one cycle after the edge.
- dn_bp_in is sampled at the edge. No combinational path from dn_bp_in to any output.
- occupancy = count.
- fwd_count wraps at 2^64; wrap is not expected in simulation.
- Packet fields pass through unmodified; the block does not alter the timestamp.

Decomposition:
- Shared package ring_noc_pkg, used by router and generators as well:
  - localparams PKT_W=49, VALID_BIT=48.
  - Field slices TS_MSB/TS_LSB (47/32), SRC_MSB/SRC_LSB (31/16), DST_MSB/DST_LSB (15/0).
  - typedef ring_pkt_t (packed struct: valid, ts, src, dst).
  - Port encoding constants PORT_LOCAL=2'b00, PORT_EAST=2'b01, PORT_WEST=2'b10.
- Sub-module ring_link_fifo: circular buffer with push/pop/count/full/empty and no policy. ring_link_buffer adds backpressure, drop policy, output register and counters.

Test Plan:
- Single packet: reset, dn_bp_in=0. Drive one packet 49'h1_0005_0002_0001 for 1 cycle at edge 10 → dn_pkt_out equals it for exactly 1 cycle after edge 11, fwd_count=1, occupancy back to 0, up_bp_out never 1.
- Stream with backpressure: dn_bp_in=1, push valid packets every cycle.
  - After 3 pushes, up_bp_out=1 (free=1<2) and count grows to 4.
  - A 5th push with no pop → drop_count=1, overflow=1, stored 4 packets intact.
  - Release dn_bp_in → 4 packets emerge in order on consecutive cycles and fwd_count=4.
- Full simultaneous push/pop: fill to 4, set dn_bp_in=0 and push every cycle for 10 cycles → no drops, occupancy stays 4, output order equals input order, pointers wrap cleanly past DEPTH.
- Invalid inputs: drive 49'h0_FFFF_FFFF_FFFF (VALID=0) for 5 cycles → occupancy 0, dn_pkt_out 0, counters unchanged.
- Reset mid-operation: 3 entries held with dn_bp_in=1, assert rst_n=0 asynchronously between edges → all outputs 0 immediately. After release, the next pushed packet emerges 2 cycles later and no stale packet appears.
- Saturation: force drop_count to 32'hFFFF_FFFE, cause 3 drops → drop_count holds at 32'hFFFF_FFFF.
